// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline issue controller.
package pipe_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    // Instruction that issued last cycle and now sits in register read.
    // addr is zero when the instruction does not write the register file.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              is_mul;
    } issue_rec_t;

    // Register 0 is hardwired zero and never tracked.
    function automatic logic is_reg(input logic [ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode / writeback / flush handshake between the pipeline and its issue controller.
interface pipeline_ctrl_if;
    import pipe_pkg::*;

    logic                dec_valid;
    logic [ADDR_W-1:0]   dec_read_addr_a;
    logic [ADDR_W-1:0]   dec_read_addr_b;
    logic                dec_reads_a;
    logic                dec_reads_b;
    logic [ADDR_W-1:0]   dec_write_addr;
    logic                dec_int_write_enable;
    logic                dec_is_mul;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_write_addr;
    logic                wb_int_write_enable;
    logic                flush;

    logic                issue;
    logic                stall_fetch;
    logic                stall_dec;
    logic                bubble;
    logic                mul_busy;
    logic [NUM_REGS-1:0] pending;

    // Pipeline side: presents decode/writeback state, consumes stall controls.
    modport master (
        output dec_valid, dec_read_addr_a, dec_read_addr_b, dec_reads_a, dec_reads_b,
               dec_write_addr, dec_int_write_enable, dec_is_mul,
               wb_valid, wb_write_addr, wb_int_write_enable, flush,
        input  issue, stall_fetch, stall_dec, bubble, mul_busy, pending
    );

    // Controller side.
    modport slave (
        input  dec_valid, dec_read_addr_a, dec_read_addr_b, dec_reads_a, dec_reads_b,
               dec_write_addr, dec_int_write_enable, dec_is_mul,
               wb_valid, wb_write_addr, wb_int_write_enable, flush,
        output issue, stall_fetch, stall_dec, bubble, mul_busy, pending
    );

endinterface

// File: rtl/pipeline_ctrl_scoreboard.sv
// Per-register in-flight write tracking with two read ports.
module pipeline_ctrl_scoreboard
    import pipe_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic                fclr_en,
    input  logic [ADDR_W-1:0]   fclr_addr,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                rd_a,
    output logic                rd_b,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clears first, then set, so a new writer wins over a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (fclr_en) begin
            pending_d[fclr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd_a    = pending_q[rd_addr_a];
    assign rd_b    = pending_q[rd_addr_b];
    assign pending = pending_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Issue controller: RAW/WAW stall against the scoreboard, multiply sequencing,
// and scoreboard cleanup of the instruction killed in register read on flush.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   MUL_IDLE | execute free; decode may issue when hazards allow
//   MUL_BUSY | multiply occupying execute; cnt_q cycles left including this one
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input logic            clock,
    input logic            reset,
    pipeline_ctrl_if.slave bus
);

    localparam int              CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              MUL_MULTI = (MUL_LATENCY > 1);

    mul_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mul_busy_q;
    issue_rec_t          rec_q;
    issue_rec_t          rec_d;
    logic [NUM_REGS-1:0] pending;
    logic                pend_a;
    logic                pend_b;
    logic                raw;
    logic                waw;
    logic                issue_c;
    logic                set_en;
    logic                clr_en;
    logic                fclr_en;
    logic                flush_mul;

    pipeline_ctrl_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (set_en),
        .set_addr  (bus.dec_write_addr),
        .clr_en    (clr_en),
        .clr_addr  (bus.wb_write_addr),
        .fclr_en   (fclr_en),
        .fclr_addr (rec_q.addr),
        .rd_addr_a (bus.dec_read_addr_a),
        .rd_addr_b (bus.dec_read_addr_b),
        .rd_a      (pend_a),
        .rd_b      (pend_b),
        .pending   (pending)
    );

    // Hazard detection and issue decision; no bypass from a same-cycle writeback.
    always_comb begin
        raw     = (bus.dec_reads_a && is_reg(bus.dec_read_addr_a) && pend_a) ||
                  (bus.dec_reads_b && is_reg(bus.dec_read_addr_b) && pend_b);
        waw     = bus.dec_int_write_enable && pending[bus.dec_write_addr];
        issue_c = !reset && bus.dec_valid && !raw && !waw && !mul_busy_q && !bus.flush;
    end

    // Scoreboard update requests and the flushed-record decode.
    always_comb begin
        set_en    = issue_c && bus.dec_int_write_enable && is_reg(bus.dec_write_addr);
        clr_en    = bus.wb_valid && bus.wb_int_write_enable && is_reg(bus.wb_write_addr);
        fclr_en   = bus.flush && rec_q.valid && is_reg(rec_q.addr);
        flush_mul = bus.flush && rec_q.valid && rec_q.is_mul;
    end

    // Next issue record: whatever issued this cycle, or an empty slot.
    always_comb begin
        rec_d        = '0;
        rec_d.valid  = issue_c;
        rec_d.is_mul = issue_c && bus.dec_is_mul;
        if (issue_c && bus.dec_int_write_enable) begin
            rec_d.addr = bus.dec_write_addr;
        end
    end

    // Issue record register; flush kills the register-read instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_q <= '0;
        end else if (bus.flush) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    // Multiply occupancy FSM with a down-counter terminating at 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= MUL_IDLE;
            cnt_q      <= '0;
            mul_busy_q <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (issue_c && bus.dec_is_mul && MUL_MULTI) begin
                        state_q    <= MUL_BUSY;
                        cnt_q      <= CNT_LOAD;
                        mul_busy_q <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (flush_mul || cnt_q == CNT_ONE) begin
                        state_q    <= MUL_IDLE;
                        cnt_q      <= '0;
                        mul_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= MUL_IDLE;
                    cnt_q      <= '0;
                    mul_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue       = issue_c;
    assign bus.stall_fetch = !reset && bus.dec_valid && !issue_c && !bus.flush;
    assign bus.stall_dec   = !reset && bus.dec_valid && !issue_c && !bus.flush;
    assign bus.bubble      = !issue_c;
    assign bus.mul_busy    = mul_busy_q;
    assign bus.pending     = pending;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-count reference model.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    localparam int L = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(.MUL_LATENCY(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // stimulus copies
    bit s_dv, s_ra, s_rb, s_we, s_mul, s_wbv, s_wbwe, s_fl;
    int s_a, s_b, s_wa, s_wba;

    // reference model
    bit m_pend[NUM_REGS];
    int cyc      = 0;
    int busy_end = -1;
    bit rec_v;
    int rec_wr;
    bit rec_mul;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return cyc <= busy_end;
    endfunction

    function automatic logic [NUM_REGS-1:0] m_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit m_issue();
        bit raw, waw;
        raw = (s_ra && s_a != 0 && m_pend[s_a]) || (s_rb && s_b != 0 && m_pend[s_b]);
        waw = s_we && s_wa != 0 && m_pend[s_wa];
        return s_dv && !s_fl && !m_busy() && !raw && !waw;
    endfunction

    task automatic m_update(input bit iss);
        if (s_wbv && s_wbwe && s_wba != 0) m_pend[s_wba] = 1'b0;
        if (s_fl && rec_v && rec_wr != 0) m_pend[rec_wr] = 1'b0;
        if (s_fl && rec_v && rec_mul) busy_end = cyc;
        if (iss && s_we && s_wa != 0) m_pend[s_wa] = 1'b1;
        if (iss && s_mul && L > 1) busy_end = cyc + L - 1;
        rec_v   = iss;
        rec_wr  = (iss && s_we) ? s_wa : 0;
        rec_mul = iss && s_mul;
        cyc++;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
        busy_end = -1;
        rec_v    = 1'b0;
        rec_wr   = 0;
        rec_mul  = 1'b0;
    endtask

    task automatic set_in(input bit dv, input bit ra, input int a, input bit rb, input int b,
                          input bit we, input int wa, input bit mul,
                          input bit wbv, input bit wbwe, input int wba, input bit fl);
        s_dv = dv; s_ra = ra; s_a = a; s_rb = rb; s_b = b; s_we = we; s_wa = wa;
        s_mul = mul; s_wbv = wbv; s_wbwe = wbwe; s_wba = wba; s_fl = fl;
        bus.dec_valid            = dv;
        bus.dec_reads_a          = ra;
        bus.dec_read_addr_a      = ADDR_W'(a);
        bus.dec_reads_b          = rb;
        bus.dec_read_addr_b      = ADDR_W'(b);
        bus.dec_int_write_enable = we;
        bus.dec_write_addr       = ADDR_W'(wa);
        bus.dec_is_mul           = mul;
        bus.wb_valid             = wbv;
        bus.wb_int_write_enable  = wbwe;
        bus.wb_write_addr        = ADDR_W'(wba);
        bus.flush                = fl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check combinational outputs mid-cycle, then registered state after the edge.
    task automatic step(output bit di);
        bit e_iss, e_stall;
        @(negedge clock);
        e_iss   = m_issue();
        e_stall = s_dv && !e_iss && !s_fl;
        chk("issue", bus.issue, e_iss);
        chk("stall_fetch", bus.stall_fetch, e_stall);
        chk("stall_dec", bus.stall_dec, e_stall);
        chk("bubble", bus.bubble, !e_iss);
        di = bus.issue;
        m_update(e_iss);
        @(posedge clock);
        #1;
        chk("pending", bus.pending, m_vec());
        chk("mul_busy", bus.mul_busy, m_busy());
    endtask

    // Asynchronous reset with an otherwise-issuable instruction presented.
    task automatic do_reset();
        reset = 1'b1;
        set_in(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pending", bus.pending, 0);
        chk("rst_mul_busy", bus.mul_busy, 0);
        chk("rst_bubble", bus.bubble, 1);
        chk("rst_issue", bus.issue, 0);
        chk("rst_stall_dec", bus.stall_dec, 0);
        chk("rst_stall_fetch", bus.stall_fetch, 0);
        m_reset();
        idle();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit di;
        int k_iss;
        int busy_cnt;

        idle();
        do_reset();

        // RAW: ADD x3, then a reader of x3 waits for the writeback at t+3
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step(di);
        chk("add_x3_issue", di, 1);
        k_iss = 0;
        for (int k = 1; k <= 6 && k_iss == 0; k++) begin
            set_in(1, 1, 3, 0, 0, 1, 10, 0, k == 3, k == 3, 3, 0);
            step(di);
            if (di) k_iss = k;
        end
        chk("raw_issue_cycle", k_iss, 4);

        // WAW: x10 pending, new writer of x10 with no reads
        k_iss = 0;
        for (int k = 1; k <= 6 && k_iss == 0; k++) begin
            set_in(1, 0, 0, 0, 0, 1, 10, 0, k == 2, k == 2, 10, 0);
            step(di);
            if (di) k_iss = k;
        end
        chk("waw_issue_cycle", k_iss, 3);
        chk("waw_new_writer_pending", bus.pending[10], 1);

        // MUL occupies execute for L cycles
        set_in(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0);
        step(di);
        chk("mul_issue", di, 1);
        k_iss    = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 8 && k_iss == 0; k++) begin
            if (bus.mul_busy) busy_cnt++;
            set_in(1, 1, 1, 1, 2, 1, 13, 0, 0, 0, 0, 0);
            step(di);
            if (di) k_iss = k;
        end
        chk("mul_busy_cycles", busy_cnt, L - 1);
        chk("after_mul_issue_cycle", k_iss, L);

        // flush kills the register-read writer of x9
        set_in(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        step(di);
        chk("x9_issue", di, 1);
        set_in(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 1);
        step(di);
        chk("flush_no_issue", di, 0);
        chk("flush_clears_x9", bus.pending[9], 0);

        // flushed multiply releases execute
        set_in(1, 0, 0, 0, 0, 1, 14, 1, 0, 0, 0, 0);
        step(di);
        chk("mul14_issue", di, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(di);
        chk("flushed_mul_idle", bus.mul_busy, 0);
        chk("flushed_mul_x14", bus.pending[14], 0);
        set_in(1, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0);
        step(di);
        chk("issue_after_mul_flush", di, 1);

        // same-cycle writeback clear and issue set of x4
        set_in(1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 4, 0);
        step(di);
        chk("set_wins_x4", bus.pending[4], 1);

        // x0 never tracked, never a hazard
        set_in(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(di);
        chk("x0_issue", di, 1);
        chk("x0_never_pending", bus.pending[0], 0);

        // reset in the middle of a multiply with x5 pending
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0);
        step(di);
        chk("mul5_busy", bus.mul_busy, 1);
        chk("mul5_pending", bus.pending[5], 1);
        do_reset();

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            set_in($urandom_range(0, 9) < 8,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8, $urandom_range(0, 7),
                   $urandom_range(0, 99) < 8);
            step(di);
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Issue controller for the five-stage integer pipeline (fetch, decode, register read, execute, writeback). It keeps a per-register scoreboard of in-flight writes and stalls decode on RAW and WAW hazards. It also sequences the multi-cycle multiply path in execute and cleans up scoreboard state when execute flushes the younger stages. Its outputs drive the enables of fetch_dec_latch and dec_reg_latch and the bubble (NOP-insert) input of dec_reg_latch.

## Interface
- NUM_REGS, 32, integer register count; register 0 is hardwired zero.
- ADDR_W, 5, register address width, equal to clog2(NUM_REGS).
- MUL_LATENCY, 4, cycles a multiply occupies execute; minimum 1.
- clock  in  1  pipeline clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_read_addr_a / dec_read_addr_b  in  ADDR_W  source register addresses.
- dec_reads_a / dec_reads_b  in  1  the instruction actually uses that source.
- dec_write_addr  in  ADDR_W  destination register.
- dec_int_write_enable  in  1  the instruction writes the integer register file.
- dec_is_mul  in  1  the instruction is a multi-cycle multiply.
- wb_valid  in  1  writeback stage holds a valid instruction.
- wb_write_addr  in  ADDR_W  writeback destination.
- wb_int_write_enable  in  1  writeback writes the register file this cycle.
- flush  in  1  execute redirects; instructions in decode and register read are killed.
- issue  out  1  decode instruction advances into register read this cycle.
- stall_fetch  out  1  hold fetch and fetch_dec_latch.
- stall_dec  out  1  hold decode.
- bubble  out  1  load a NOP into dec_reg_latch.
- mul_busy  out  1  multiply FSM is in BUSY.
- pending  out  NUM_REGS  scoreboard bits, exported for debug.

## Operation
- Scoreboard: one bit per register.
  - A bit is set on issue when dec_int_write_enable=1 and dec_write_addr≠0.
  - A bit is cleared when wb_valid && wb_int_write_enable && wb_write_addr≠0.
  - Bit 0 is always 0.
- Hazard:
  - raw = (dec_reads_a && pending[a]) || (dec_reads_b && pending[b]), ignoring address 0.
  - waw = dec_int_write_enable && pending[dec_write_addr].
  - There is no same-cycle bypass. A bit being cleared this cycle still counts as a hazard.
- issue = dec_valid && !raw && !waw && !mul_busy && !flush.
- Outputs:
  - stall_fetch = stall_dec = dec_valid && !issue && !flush.
  - bubble = !issue.
- Issue record: a one-entry register {valid, addr, is_mul} holding the instruction issued last cycle (now in register read). It loads on every clock: the issued instruction's fields, or valid=0 if nothing issued.
- Flush:
  - If the record is valid and wrote a register, clear that pending bit. This is safe because the WAW stall guarantees at most one writer per register.
  - If the record is a multiply, the FSM returns to IDLE.
  - The record is invalidated.
  - No issue occurs in the flush cycle.
- Multiply FSM:
  - IDLE → BUSY when a multiply issues and MUL_LATENCY>1. The counter loads MUL_LATENCY-1.
  - In BUSY the counter decrements each cycle. At 1 → IDLE.
  - MUL_LATENCY=1 never enters BUSY.
- Simultaneous set and clear of the same register in one cycle: set wins. The new writer stays pending.
- Simultaneous flush-clear and writeback-clear: both apply.

## Timing
- Reset values:
  - pending=0, record invalid, FSM IDLE, counter 0.
  - issue=0, stall_fetch=0, stall_dec=0, bubble=1, mul_busy=0.
- Reset mid-operation drops all in-flight state immediately.
- issue, stall_*, and bubble are combinational from inputs and state in the same cycle.
- Scoreboard, record, and FSM update on the rising clock edge.
- A dependent instruction issues in the cycle after its producer's writeback cycle. Producer issues at cycle t, writes back at t+3, and the consumer issues at t+4 at the earliest.
- Multiply issued at t: mul_busy is high for cycles t+1 through t+MUL_LATENCY-1. The next issue is possible at t+MUL_LATENCY.

## Structure
- Shared package pipe_pkg:
  - ADDR_W and NUM_REGS constants.
  - mul_state_t enum {MUL_IDLE, MUL_BUSY}.
  - Issue-record struct type.
- Sub-module scoreboard: pending register array with set, clear, and flush-clear ports, plus two read ports.
- FSM, issue record, and stall logic live in pipeline_ctrl.

## Test plan
- Reset mid-BUSY with pending[5]=1 → pending=0, mul_busy=0, bubble=1 while reset is high.
- ADD x3 issues at t; next instruction reads x3 → stall_dec=1 for t+1 through t+3; issue at t+4 after the wb clear at t+3.
- Write x7 pending, new instruction writes x7 with no reads → stall (WAW) until wb clears x7.
- MUL issue with MUL_LATENCY=4 → mul_busy high for 3 cycles; independent ADD issues at t+4.
- Issue writing x9, then flush next cycle → pending[9]=0, no issue in the flush cycle; a flushed MUL returns the FSM to IDLE.
- Same cycle: wb clears x4 and issue sets x4 → pending[4]=1. Writes to x0 never set any bit.
